// File: rtl/mul_issue_queue.sv
// mul_issue_queue
//   Upstream sequencer for a shift-add multiplier core. Unsigned operand
//   pairs are buffered in a small FIFO and launched one at a time. Each
//   product (or a zero/timeout marker if the core never finishes) is handed
//   back in push order. At most one operation is in flight at any time.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
//   are both high. valid must not depend on ready. Once out_valid is high,
//   out_y and out_timeout stay stable until the transfer completes.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand pair handshake; in_ready = fifo_count < DEPTH
//   in_a, in_b          multiplicand / multiplier (W bits, unsigned)
//   mul_a, mul_b        operands to the core, held from pop to next pop
//   mul_load            one-cycle launch pulse to the core
//   mul_y, mul_valid    core product and done flag
//   out_valid/out_ready result handshake
//   out_y               2*W-bit product, 0 when aborted
//   out_timeout         1 when the operation was aborted by the watchdog
//   busy                FSM is anywhere other than IDLE
//   fifo_count          current FIFO occupancy
//   dbg_state           current FSM state encoding (for checkers)

module mul_issue_queue #(
   parameter int W       = 32,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 100
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [W-1:0]             in_a,
   input  logic [W-1:0]             in_b,
   output logic [W-1:0]             mul_a,
   output logic [W-1:0]             mul_b,
   output logic                     mul_load,
   input  logic [2*W-1:0]           mul_y,
   input  logic                     mul_valid,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [2*W-1:0]           out_y,
   output logic                     out_timeout,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [2:0]               dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_LAUNCH    = 3'd1;
   localparam logic [2:0] S_WAIT_LOW  = 3'd2;
   localparam logic [2:0] S_WAIT_HIGH = 3'd3;
   localparam logic [2:0] S_HOLD      = 3'd4;

   // ---------------------------------------------------------------- FIFO
   logic [2*W-1:0] mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]  count_q;
   logic           push, pop;

   logic [2:0]     state_q, state_d;
   logic [W-1:0]   mul_a_q, mul_a_d;
   logic [W-1:0]   mul_b_q, mul_b_d;
   logic [TW-1:0]  tmo_cnt_q, tmo_cnt_d;
   logic [2*W-1:0] out_y_q, out_y_d;
   logic           out_timeout_q, out_timeout_d;
   logic           out_valid_q, out_valid_d;

   assign in_ready = (count_q < CW'(DEPTH));
   assign push     = in_valid && in_ready;
   // Pop looks only at the registered count, so an entry written this cycle
   // cannot be launched before the next one.
   assign pop      = (state_q == S_IDLE) && (count_q != '0);

   // Storage is not reset: entries are only ever read after being written.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {in_a, in_b};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // ----------------------------------------------------------------- FSM
   always_comb begin
      state_d       = state_q;
      mul_a_d       = mul_a_q;
      mul_b_d       = mul_b_q;
      tmo_cnt_d     = tmo_cnt_q;
      out_y_d       = out_y_q;
      out_timeout_d = out_timeout_q;
      out_valid_d   = out_valid_q;
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               {mul_a_d, mul_b_d} = mem_q[rd_ptr_q];
               tmo_cnt_d          = '0;
               state_d            = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            state_d = S_WAIT_LOW;
         end
         S_WAIT_LOW, S_WAIT_HIGH: begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            // Completion is checked before the watchdog so it wins a tie.
            if ((state_q == S_WAIT_HIGH) && mul_valid) begin
               out_y_d       = mul_y;
               out_timeout_d = 1'b0;
               out_valid_d   = 1'b1;
               state_d       = S_HOLD;
            end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
               // Counter reaches TIMEOUT on this edge.
               out_y_d       = '0;
               out_timeout_d = 1'b1;
               out_valid_d   = 1'b1;
               state_d       = S_HOLD;
            end else if ((state_q == S_WAIT_LOW) && !mul_valid) begin
               // A done flag left high from before the launch is ignored
               // until it has been seen low once.
               state_d = S_WAIT_HIGH;
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         mul_a_q       <= '0;
         mul_b_q       <= '0;
         tmo_cnt_q     <= '0;
         out_y_q       <= '0;
         out_timeout_q <= 1'b0;
         out_valid_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         mul_a_q       <= mul_a_d;
         mul_b_q       <= mul_b_d;
         tmo_cnt_q     <= tmo_cnt_d;
         out_y_q       <= out_y_d;
         out_timeout_q <= out_timeout_d;
         out_valid_q   <= out_valid_d;
      end
   end

   assign mul_a       = mul_a_q;
   assign mul_b       = mul_b_q;
   assign mul_load    = (state_q == S_LAUNCH);
   assign out_valid   = out_valid_q;
   assign out_y       = out_y_q;
   assign out_timeout = out_timeout_q;
   assign busy        = (state_q != S_IDLE);
   assign fifo_count  = count_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_mul_issue_queue.sv
// tb_mul_issue_queue
//   Directed bench for mul_issue_queue with a behavioural multiplier core.
//   A vector table covers single operations; hand-written sequences cover
//   backpressure, result hold, timeout and reset mid-operation.

module tb_mul_issue_queue;

   localparam int W = 32;
   localparam logic [2:0] ST_WAIT_LOW  = 3'd2;
   localparam logic [2:0] ST_WAIT_HIGH = 3'd3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_a = '0;
   logic [W-1:0]  in_b = '0;
   logic [W-1:0]  mul_a, mul_b;
   logic          mul_load;
   logic [63:0]   mul_y;
   logic          mul_valid;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [63:0]   out_y;
   logic          out_timeout;
   logic          busy;
   logic [2:0]    fifo_count;
   logic [2:0]    dbg_state;

   int total = 0;
   int bad   = 0;
   logic [64:0] exp_q[$];

   // ------------------------------------------------------ clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1, "watchdog");
   end

   mul_issue_queue #(.W(W), .DEPTH(4), .TIMEOUT(100)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_load    (mul_load),
      .mul_y       (mul_y),
      .mul_valid   (mul_valid),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_y       (out_y),
      .out_timeout (out_timeout),
      .busy        (busy),
      .fifo_count  (fifo_count),
      .dbg_state   (dbg_state)
   );

   // --------------------------------------------------------- core model
   // Samples a/b when load is seen, finishes lat cycles later and leaves
   // its done flag high until the next load. hang masks the flag, stale
   // forces it high.
   logic [W-1:0] cap_a = '0;
   logic [W-1:0] cap_b = '0;
   logic [63:0]  core_y = '0;
   logic         core_valid = 1'b0;
   int           core_cnt = 0;
   int           lat = 5;
   logic         hang = 1'b0;
   logic         stale = 1'b0;

   always @(posedge clk) begin
      if (mul_load) begin
         cap_a      <= mul_a;
         cap_b      <= mul_b;
         core_valid <= 1'b0;
         core_cnt   <= lat;
      end else if (core_cnt > 0) begin
         core_cnt <= core_cnt - 1;
         if (core_cnt == 1) begin
            core_valid <= 1'b1;
            core_y     <= {32'b0, cap_a} * {32'b0, cap_b};
         end
      end
   end

   assign mul_valid = (core_valid && !hang) || stale;
   assign mul_y     = core_y;

   // ---------------------------------------------------------- checking
   function automatic void check(input string name, input logic [64:0] act,
                                 input logic [64:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   int load_cnt = 0;
   int ov_cyc   = 0;

   // Scoreboard: each accepted result is compared with the oldest expected.
   always @(negedge clk) begin
      if (rst_n) begin
         if (mul_load)  load_cnt++;
         if (out_valid) ov_cyc++;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", {out_timeout, out_y}, 65'h1_dead_beef_dead_beef);
            end else begin
               check("result", {out_timeout, out_y}, exp_q.pop_front());
            end
         end
      end
   end

   // ------------------------------------------------------------ drivers
   // All driver tasks start and end at a falling edge.
   task automatic push(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [64:0] e);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("push_stall", 65'(in_ready), 65'd1);
      end else begin
         exp_q.push_back(e);
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   // out_ready changes just after a rising edge so the monitor sees it at
   // the falling edge before it takes effect.
   task automatic set_ready(input logic v);
      @(posedge clk);
      #1 out_ready = v;
      @(negedge clk);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0 || busy) check("drain_timeout", 65'(exp_q.size()), 65'd0);
   endtask

   task automatic wait_state(input logic [2:0] st, input int budget);
      int n;
      n = 0;
      while (dbg_state != st && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (dbg_state != st) check("wait_state", 65'(dbg_state), 65'(st));
   endtask

   task automatic wait_ov(input int budget);
      int n;
      n = 0;
      while (!out_valid && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) check("wait_out_valid", 65'(out_valid), 65'd1);
   endtask

   // --------------------------------------------------------------- test
   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [63:0]  y;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int l0, v0, n, f0;
      logic [63:0] y0;
      logic        stable;

      vecs[0] = '{32'd3,          32'd5,          64'd15};
      vecs[1] = '{32'h7800_0000,  32'hF800_0000,  64'h7440_0000_0000_0000};
      vecs[2] = '{32'd0,          32'hFFFF_FFFF,  64'd0};
      vecs[3] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
      vecs[4] = '{32'd1,          32'h1234_5678,  64'h1234_5678};
      vecs[5] = '{32'h0001_0000,  32'h0001_0000,  64'h1_0000_0000};

      // Reset values.
      repeat (3) @(negedge clk);
      check("rst_out_valid",   65'(out_valid),   65'd0);
      check("rst_busy",        65'(busy),        65'd0);
      check("rst_mul_load",    65'(mul_load),    65'd0);
      check("rst_fifo_count",  65'(fifo_count),  65'd0);
      check("rst_in_ready",    65'(in_ready),    65'd1);
      check("rst_out_y",       {out_timeout, out_y}, 65'd0);
      check("rst_mul_ab",      65'({mul_a, mul_b}), 65'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Table: one operation at a time with out_ready high.
      for (int i = 0; i < 6; i++) begin
         l0 = load_cnt;
         v0 = ov_cyc;
         push(vecs[i].a, vecs[i].b, {1'b0, vecs[i].y});
         drain(300);
         check("load_pulses",  65'(load_cnt - l0), 65'd1);
         check("valid_cycles", 65'(ov_cyc - v0),   65'd1);
         check("busy_after",   65'(busy),          65'd0);
      end

      // Fill and backpressure, then result hold.
      lat = 4;
      set_ready(1'b0);
      for (int i = 1; i <= 5; i++) begin
         push(W'(i), W'(i + 1), 65'(i * (i + 1)));
      end
      in_valid = 1'b1;
      in_a     = 32'd6;
      in_b     = 32'd7;
      wait_ov(60);
      check("fill_count",    65'(fifo_count), 65'd4);
      check("fill_in_ready", 65'(in_ready),   65'd0);
      check("hold_first_y",  {out_timeout, out_y}, 65'd2);
      y0     = out_y;
      l0     = load_cnt;
      f0     = int'(fifo_count);
      stable = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (out_y !== y0 || !out_valid || out_timeout) stable = 1'b0;
      end
      check("hold_stable",   65'(stable),          65'd1);
      check("hold_no_load",  65'(load_cnt - l0),   65'd0);
      check("hold_count",    65'(fifo_count),      65'(f0));
      exp_q.push_back(65'd42);
      set_ready(1'b1);
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("sixth_accepted", 65'(in_ready), 65'd1);
      @(negedge clk);
      in_valid = 1'b0;
      drain(600);

      // Timeout with a hung core, then a normal operation behind it.
      set_ready(1'b0);
      hang = 1'b1;
      push(32'd11, 32'd13, {1'b1, 64'd0});
      push(32'd5,  32'd6,  65'd30);
      wait_state(ST_WAIT_LOW, 50);
      n = 0;
      while (!out_valid && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("timeout_latency", 65'(n), 65'd100);
      check("timeout_flag",    {out_timeout, out_y}, {1'b1, 64'd0});
      hang = 1'b0;
      set_ready(1'b1);
      drain(300);

      // Reset during WAIT_HIGH with two entries queued.
      lat = 20;
      push(32'h100, 32'd2, 65'h200);
      push(32'h200, 32'd2, 65'h400);
      push(32'h300, 32'd2, 65'h600);
      wait_state(ST_WAIT_HIGH, 50);
      check("pre_reset_count", 65'(fifo_count), 65'd2);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 65'(out_valid),  65'd0);
      check("mid_rst_busy",  65'(busy),       65'd0);
      check("mid_rst_load",  65'(mul_load),   65'd0);
      check("mid_rst_count", 65'(fifo_count), 65'd0);
      check("mid_rst_out",   {out_timeout, out_y}, 65'd0);
      check("mid_rst_mul",   65'({mul_a, mul_b}),  65'd0);
      exp_q.delete();
      stale = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      push(32'd7, 32'd9, 65'd63);
      repeat (8) @(negedge clk);
      check("stale_guard_state", 65'(dbg_state), 65'(ST_WAIT_LOW));
      check("stale_guard_valid", 65'(out_valid), 65'd0);
      stale = 1'b0;
      drain(300);

      check("queue_empty", 65'(exp_q.size()), 65'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
